// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, NUM_DATA_BITS data bits LSB first,
// optional even parity, one stop bit. Bit timing from a clocks-per-bit counter.
module uart_frame_tx #(
    parameter int NUM_DATA_BITS   = 8,
    parameter int BIT_PERIOD_BITS = 14
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       tx_start,
    input  logic [NUM_DATA_BITS-1:0]   tx_data,
    input  logic                       parity_en,
    input  logic [BIT_PERIOD_BITS-1:0] bit_period,
    output logic                       tx_ready,
    output logic                       serial_out,
    output logic                       tx_done
);
    localparam int IDX_W = $clog2(NUM_DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t                     state, next_state;
    logic [NUM_DATA_BITS-1:0]   shreg, shreg_next;
    logic [BIT_PERIOD_BITS-1:0] bp_q, tcnt, tcnt_next;
    logic [IDX_W-1:0]           bidx, bidx_next;
    logic                       par_en_q, par_bit;
    logic                       so_next;
    logic                       accept, active, bit_end;

    assign tx_ready = (state == IDLE) || (state == DONE);
    assign tx_done  = (state == DONE);
    assign accept   = tx_ready && tx_start;
    assign active   = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign bit_end  = active && (tcnt == bp_q);

    always_comb begin
        next_state = state;
        shreg_next = shreg;
        bidx_next  = bidx;
        tcnt_next  = tcnt;
        so_next    = 1'b1;

        case (state)
            IDLE, DONE: begin
                if (tx_start) begin
                    next_state = START;
                    shreg_next = tx_data;
                end else begin
                    next_state = IDLE;
                end
            end
            START:  if (bit_end) next_state = DATA;
            DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bidx == IDX_W'(NUM_DATA_BITS - 1))
                        next_state = par_en_q ? PARITY : STOP;
                    else
                        bidx_next = bidx + IDX_W'(1);
                end
            end
            PARITY: if (bit_end) next_state = STOP;
            STOP:   if (bit_end) next_state = DONE;
            default: next_state = IDLE;
        endcase

        // Counter runs 1..bp, so a clear loads 1 when entering a timed bit.
        if (next_state != state) begin
            tcnt_next = (next_state == IDLE || next_state == DONE) ? '0 : BIT_PERIOD_BITS'(1);
            bidx_next = '0;
        end else if (bit_end) begin
            tcnt_next = BIT_PERIOD_BITS'(1);
        end else if (active) begin
            tcnt_next = tcnt + BIT_PERIOD_BITS'(1);
        end

        // Line level is decided from the next state so the output flop
        // changes on the same edge as the state.
        case (next_state)
            START:   so_next = 1'b0;
            DATA:    so_next = shreg_next[0];
            PARITY:  so_next = par_bit;
            default: so_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shreg      <= '0;
            tcnt       <= '0;
            bidx       <= '0;
            bp_q       <= '0;
            par_en_q   <= 1'b0;
            par_bit    <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            state      <= next_state;
            shreg      <= shreg_next;
            tcnt       <= tcnt_next;
            bidx       <= bidx_next;
            serial_out <= so_next;
            if (accept) begin
                bp_q     <= (bit_period == '0) ? BIT_PERIOD_BITS'(1) : bit_period;
                par_en_q <= parity_en;
                par_bit  <= ^tx_data;
            end
        end
    end
endmodule
